decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Second stage of the ARM pipeline. Sits directly downstream of fetch and consumes its instPipeOut and pcPlus4.
- Holds the 16x32 register file, decodes the instruction into control signals, and reads operands.
- Extends immediates and registers everything into the ID/EX pipeline register feeding execute.
- Supports stall (hold), flush (bubble) and a writeback port with same-cycle bypass.

Parameters:
- REGS, 16, number of architectural registers; R15 is the PC and is never stored.
- WIDTH, 32, datapath width.

Ports:
- clock  in  1  rising-edge clock
- clr  in  1  asynchronous active-low reset
- pipeEnable  in  1  1 = load ID/EX register; 0 = hold (stall)
- flushPipe  in  1  synchronous bubble insert
- instIn  in  32  instruction from fetch
- pcPlus4In  in  32  PC+4 from fetch
- wbEnable  in  1  register-file write enable
- wbAddr  in  4  write address
- wbData  in  32  write data
- rd1Out  out  32  operand A
- rd2Out  out  32  operand B / store data
- immOut  out  32  extended immediate
- ra1Out, ra2Out, rdAddrOut  out  4 each  source and destination register numbers, for the hazard unit
- condOut  out  4  instr[31:28]
- aluCtrlOut  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- aluSrcOut, setFlagsOut, memWriteOut, memToRegOut, regWriteOut, branchOut, validOut  out  1 each

Behaviour:
- Reset (clr=0, asynchronous):
  - All ID/EX outputs are 0.
  - All 15 stored registers are 0.
- Priority at each rising edge: clr > flushPipe > pipeEnable.
- Flush:
  - All outputs load 0, including validOut.
  - Applies even when pipeEnable=0.
- Hold: when pipeEnable=0 and there is no flush, all outputs hold their values.
- Latency: instIn decoded in cycle N appears on the outputs after edge N+1.
- Register-file writes:
  - Occur on the rising edge when wbEnable=1, independent of pipeEnable and flushPipe.
  - wbAddr=15 is ignored.
- Reads are combinational.
  - Bypass: if wbEnable=1, wbAddr==raX and raX!=15, the read returns wbData.
  - A read of R15 returns pcPlus4In+4 (PC+8).
- Opcode op=instr[27:26]:
  - 00 data-processing:
    - I=instr[25], cmd=instr[24:21], S=instr[20], ra1=instr[19:16], ra2=instr[3:0], rd=instr[15:12].
    - cmd 0100 → ADD, 0010 → SUB, 0000 → AND, 1100 → ORR; each has regWrite=1 and setFlags=S.
    - cmd 1010 (CMP) → SUB, regWrite=0, setFlags=1.
    - Any other cmd → all controls 0 and validOut=1 (NOP).
    - aluSrc=I. imm = zero-extend instr[7:0]; the rotate field is ignored.
  - 01 memory:
    - L=instr[20], aluCtrl=ADD, aluSrc=1, imm = zero-extend instr[11:0].
    - LDR (L=1): regWrite=1, memToReg=1, ra2=instr[3:0].
    - STR (L=0): memWrite=1, ra2=instr[15:12].
  - 10 branch:
    - branch=1, ra1=15, aluCtrl=ADD, aluSrc=1.
    - imm = sign-extend(instr[23:0]) << 2, i.e. {{6{instr[23]}},instr[23:0],2'b00}.
  - 11: all controls 0, validOut=0.
- validOut=1 for every loaded instruction except opcode 11 and flush.
- Width rules: all sums wrap modulo 2^32, with no overflow detection.

Test Plan:
- Reset and write: clr=0 then 1; write R3=0x1234 via wb; decode E0831003 (ADD R1,R3,R3) → rd1Out=rd2Out=0x1234, aluCtrlOut=00, regWriteOut=1, rdAddrOut=1, validOut=1.
- Bypass: same cycle wbEnable=1, wbAddr=2, wbData=0xAAAA with instIn=E0422002 (SUB R2,R2,R2) → next edge rd1Out=rd2Out=0xAAAA, aluCtrlOut=01.
- Branch: pcPlus4In=0x100, instIn=EAFFFFFE → immOut=0xFFFFFFF8, rd1Out=0x104, branchOut=1, regWriteOut=0.
- Memory: instIn=E5934008 (LDR R4,[R3,#8]) → immOut=8, memToRegOut=1, aluSrcOut=1. instIn=E5834008 (STR) → memWriteOut=1, ra2Out=4, regWriteOut=0.
- Stall/flush: hold pipeEnable=0 for 2 cycles while instIn changes → outputs unchanged. flushPipe=1 with pipeEnable=0 → all outputs 0 next edge; a wb write in that cycle still lands.
- Async reset mid-operation: assert clr=0 between edges → outputs and registers 0 immediately; R15 reads still equal pcPlus4In+4; CMP E1530004 → setFlagsOut=1, regWriteOut=0.

Source files
------------

// File: rtl/decode_stage.sv
// Decode stage: register file with writeback bypass, instruction decode,
// immediate extension and the ID/EX pipeline register.
module decode_stage #(
  parameter int unsigned REGS  = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             pipeEnable,
  input  logic             flushPipe,
  input  logic [31:0]      instIn,
  input  logic [WIDTH-1:0] pcPlus4In,
  input  logic             wbEnable,
  input  logic [3:0]       wbAddr,
  input  logic [WIDTH-1:0] wbData,
  output logic [WIDTH-1:0] rd1Out,
  output logic [WIDTH-1:0] rd2Out,
  output logic [WIDTH-1:0] immOut,
  output logic [3:0]       ra1Out,
  output logic [3:0]       ra2Out,
  output logic [3:0]       rdAddrOut,
  output logic [3:0]       condOut,
  output logic [1:0]       aluCtrlOut,
  output logic             aluSrcOut,
  output logic             setFlagsOut,
  output logic             memWriteOut,
  output logic             memToRegOut,
  output logic             regWriteOut,
  output logic             branchOut,
  output logic             validOut
);

  localparam int unsigned STORED = REGS - 1;
  localparam logic [3:0]  PC_REG = 4'd15;
  localparam logic [1:0]  ALU_ADD = 2'b00;
  localparam logic [1:0]  ALU_SUB = 2'b01;
  localparam logic [1:0]  ALU_AND = 2'b10;
  localparam logic [1:0]  ALU_ORR = 2'b11;

  logic [WIDTH-1:0] regFile [STORED];

  logic [3:0]       ra1, ra2, rdAddr;
  logic [WIDTH-1:0] imm, rd1, rd2;
  logic [1:0]       aluCtrl;
  logic             aluSrc, setFlags, memWrite, memToReg, regWrite, branch, valid;

  // Register file: R15 is the PC and has no storage
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < int'(STORED); i++) regFile[i] <= '0;
    end else if (wbEnable && wbAddr != PC_REG) begin
      regFile[wbAddr] <= wbData;
    end
  end

  // Combinational reads: PC+8 for R15, then same-cycle writeback bypass
  assign rd1 = (ra1 == PC_REG) ? pcPlus4In + WIDTH'(4) :
               (wbEnable && wbAddr == ra1) ? wbData : regFile[ra1];
  assign rd2 = (ra2 == PC_REG) ? pcPlus4In + WIDTH'(4) :
               (wbEnable && wbAddr == ra2) ? wbData : regFile[ra2];

  // Instruction decode
  always_comb begin
    ra1      = instIn[19:16];
    ra2      = instIn[3:0];
    rdAddr   = instIn[15:12];
    imm      = WIDTH'(instIn[7:0]);
    aluCtrl  = ALU_ADD;
    aluSrc   = 1'b0;
    setFlags = 1'b0;
    memWrite = 1'b0;
    memToReg = 1'b0;
    regWrite = 1'b0;
    branch   = 1'b0;
    valid    = 1'b1;
    unique case (instIn[27:26])
      2'b00: begin
        unique case (instIn[24:21])
          4'b0100: begin aluCtrl = ALU_ADD; regWrite = 1'b1; setFlags = instIn[20]; aluSrc = instIn[25]; end
          4'b0010: begin aluCtrl = ALU_SUB; regWrite = 1'b1; setFlags = instIn[20]; aluSrc = instIn[25]; end
          4'b0000: begin aluCtrl = ALU_AND; regWrite = 1'b1; setFlags = instIn[20]; aluSrc = instIn[25]; end
          4'b1100: begin aluCtrl = ALU_ORR; regWrite = 1'b1; setFlags = instIn[20]; aluSrc = instIn[25]; end
          4'b1010: begin aluCtrl = ALU_SUB; setFlags = 1'b1; aluSrc = instIn[25]; end
          default: ;
        endcase
      end
      2'b01: begin
        aluSrc = 1'b1;
        imm    = WIDTH'(instIn[11:0]);
        if (instIn[20]) begin
          regWrite = 1'b1;
          memToReg = 1'b1;
        end else begin
          memWrite = 1'b1;
          ra2      = instIn[15:12];
        end
      end
      2'b10: begin
        branch = 1'b1;
        ra1    = PC_REG;
        aluSrc = 1'b1;
        imm    = WIDTH'({{6{instIn[23]}}, instIn[23:0], 2'b00});
      end
      default: valid = 1'b0;
    endcase
  end

  // ID/EX register: flush beats stall
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      rd1Out <= '0; rd2Out <= '0; immOut <= '0;
      ra1Out <= '0; ra2Out <= '0; rdAddrOut <= '0; condOut <= '0; aluCtrlOut <= '0;
      aluSrcOut <= 1'b0; setFlagsOut <= 1'b0; memWriteOut <= 1'b0; memToRegOut <= 1'b0;
      regWriteOut <= 1'b0; branchOut <= 1'b0; validOut <= 1'b0;
    end else if (flushPipe) begin
      rd1Out <= '0; rd2Out <= '0; immOut <= '0;
      ra1Out <= '0; ra2Out <= '0; rdAddrOut <= '0; condOut <= '0; aluCtrlOut <= '0;
      aluSrcOut <= 1'b0; setFlagsOut <= 1'b0; memWriteOut <= 1'b0; memToRegOut <= 1'b0;
      regWriteOut <= 1'b0; branchOut <= 1'b0; validOut <= 1'b0;
    end else if (pipeEnable) begin
      rd1Out <= rd1; rd2Out <= rd2; immOut <= imm;
      ra1Out <= ra1; ra2Out <= ra2; rdAddrOut <= rdAddr; condOut <= instIn[31:28];
      aluCtrlOut <= aluCtrl; aluSrcOut <= aluSrc; setFlagsOut <= setFlags;
      memWriteOut <= memWrite; memToRegOut <= memToReg; regWriteOut <= regWrite;
      branchOut <= branch; validOut <= valid;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed test of decode_stage with hand-computed expected values.
module tb_decode_stage;

  logic        clock, clr, pipeEnable, flushPipe, wbEnable;
  logic [31:0] instIn, pcPlus4In, wbData;
  logic [3:0]  wbAddr;
  logic [31:0] rd1Out, rd2Out, immOut;
  logic [3:0]  ra1Out, ra2Out, rdAddrOut, condOut;
  logic [1:0]  aluCtrlOut;
  logic        aluSrcOut, setFlagsOut, memWriteOut, memToRegOut, regWriteOut, branchOut, validOut;

  int checkCnt = 0;
  int errCnt   = 0;

  decode_stage dut (
    .clock(clock), .clr(clr), .pipeEnable(pipeEnable), .flushPipe(flushPipe),
    .instIn(instIn), .pcPlus4In(pcPlus4In), .wbEnable(wbEnable), .wbAddr(wbAddr),
    .wbData(wbData), .rd1Out(rd1Out), .rd2Out(rd2Out), .immOut(immOut),
    .ra1Out(ra1Out), .ra2Out(ra2Out), .rdAddrOut(rdAddrOut), .condOut(condOut),
    .aluCtrlOut(aluCtrlOut), .aluSrcOut(aluSrcOut), .setFlagsOut(setFlagsOut),
    .memWriteOut(memWriteOut), .memToRegOut(memToRegOut), .regWriteOut(regWriteOut),
    .branchOut(branchOut), .validOut(validOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clr = 1'b0; pipeEnable = 1'b1; flushPipe = 1'b0; wbEnable = 1'b0;
    wbAddr = 4'd0; wbData = 32'd0; instIn = 32'd0; pcPlus4In = 32'h0000_0004;
    #12;
    checkVal("rst_rd1", rd1Out, 32'd0);
    checkVal("rst_valid", 32'(validOut), 32'd0);
    checkVal("rst_regWrite", 32'(regWriteOut), 32'd0);
    @(negedge clock); clr = 1'b1;

    // write R3 = 0x1234
    wbEnable = 1'b1; wbAddr = 4'd3; wbData = 32'h1234;
    step();
    wbEnable = 1'b0;
    instIn = 32'hE083_1003;               // ADD R1,R3,R3
    step();
    checkVal("add_rd1", rd1Out, 32'h1234);
    checkVal("add_rd2", rd2Out, 32'h1234);
    checkVal("add_alu", 32'(aluCtrlOut), 32'd0);
    checkVal("add_regWrite", 32'(regWriteOut), 32'd1);
    checkVal("add_rdAddr", 32'(rdAddrOut), 32'd1);
    checkVal("add_valid", 32'(validOut), 32'd1);
    checkVal("add_cond", 32'(condOut), 32'hE);

    // same-cycle bypass of R2
    wbEnable = 1'b1; wbAddr = 4'd2; wbData = 32'hAAAA;
    instIn = 32'hE042_2002;               // SUB R2,R2,R2
    step();
    wbEnable = 1'b0;
    checkVal("byp_rd1", rd1Out, 32'hAAAA);
    checkVal("byp_rd2", rd2Out, 32'hAAAA);
    checkVal("byp_alu", 32'(aluCtrlOut), 32'd1);

    // branch back by 2 words
    pcPlus4In = 32'h100; instIn = 32'hEAFF_FFFE;
    step();
    checkVal("br_imm", immOut, 32'hFFFF_FFF8);
    checkVal("br_rd1", rd1Out, 32'h104);
    checkVal("br_branch", 32'(branchOut), 32'd1);
    checkVal("br_regWrite", 32'(regWriteOut), 32'd0);
    checkVal("br_ra1", 32'(ra1Out), 32'd15);

    instIn = 32'hE593_4008;               // LDR R4,[R3,#8]
    step();
    checkVal("ldr_imm", immOut, 32'd8);
    checkVal("ldr_memToReg", 32'(memToRegOut), 32'd1);
    checkVal("ldr_aluSrc", 32'(aluSrcOut), 32'd1);
    checkVal("ldr_rd1", rd1Out, 32'h1234);
    checkVal("ldr_ra2", 32'(ra2Out), 32'd8);

    instIn = 32'hE583_4008;               // STR R4,[R3,#8]
    step();
    checkVal("str_memWrite", 32'(memWriteOut), 32'd1);
    checkVal("str_ra2", 32'(ra2Out), 32'd4);
    checkVal("str_regWrite", 32'(regWriteOut), 32'd0);

    instIn = 32'hE182_1003;               // ORR R1,R2,R3 (R2 now from storage)
    step();
    checkVal("orr_alu", 32'(aluCtrlOut), 32'd3);
    checkVal("orr_rd1", rd1Out, 32'hAAAA);
    checkVal("orr_rd2", rd2Out, 32'h1234);

    // stall for two cycles while the input changes
    pipeEnable = 1'b0; instIn = 32'hEAFF_FFFE;
    step();
    instIn = 32'hE593_4008;
    step();
    checkVal("stall_alu", 32'(aluCtrlOut), 32'd3);
    checkVal("stall_rd1", rd1Out, 32'hAAAA);
    checkVal("stall_branch", 32'(branchOut), 32'd0);
    checkVal("stall_valid", 32'(validOut), 32'd1);

    // flush with stall asserted; a writeback to R5 still lands
    flushPipe = 1'b1; wbEnable = 1'b1; wbAddr = 4'd5; wbData = 32'h5555;
    step();
    flushPipe = 1'b0; wbEnable = 1'b0;
    checkVal("flush_valid", 32'(validOut), 32'd0);
    checkVal("flush_rd1", rd1Out, 32'd0);
    checkVal("flush_memToReg", 32'(memToRegOut), 32'd0);
    pipeEnable = 1'b1; instIn = 32'hE085_1005;   // ADD R1,R5,R5
    step();
    checkVal("flush_wb_rd1", rd1Out, 32'h5555);

    // write to R15 is dropped; reads of R15 stay PC+8
    wbEnable = 1'b1; wbAddr = 4'd15; wbData = 32'hDEAD_BEEF;
    pcPlus4In = 32'h300; instIn = 32'hE08F_1003; // ADD R1,PC,R3
    step();
    wbEnable = 1'b0;
    checkVal("r15_wb_rd1", rd1Out, 32'h304);

    instIn = 32'hE1A0_1003;               // MOV: unsupported cmd -> NOP
    step();
    checkVal("nop_valid", 32'(validOut), 32'd1);
    checkVal("nop_regWrite", 32'(regWriteOut), 32'd0);

    instIn = 32'hEC00_0000;               // opcode 11
    step();
    checkVal("op3_valid", 32'(validOut), 32'd0);

    // async reset between edges
    instIn = 32'hE085_1005;
    step();
    checkVal("pre_rst_rd1", rd1Out, 32'h5555);
    #2 clr = 1'b0;
    #1;
    checkVal("async_rd1", rd1Out, 32'd0);
    checkVal("async_valid", 32'(validOut), 32'd0);
    @(negedge clock); clr = 1'b1;
    step();
    checkVal("async_reg5", rd1Out, 32'd0);

    pcPlus4In = 32'h200; instIn = 32'hE08F_1003; // ADD R1,PC,R3
    step();
    checkVal("r15_rd1", rd1Out, 32'h204);
    checkVal("r15_rd2", rd2Out, 32'd0);

    instIn = 32'hE153_0004;               // CMP R3,R4
    step();
    checkVal("cmp_setFlags", 32'(setFlagsOut), 32'd1);
    checkVal("cmp_regWrite", 32'(regWriteOut), 32'd0);
    checkVal("cmp_alu", 32'(aluCtrlOut), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule
